// File: rtl/br_ram_flops_nr1w.sv
// br_ram_flops_nr1w: flop-array RAM with one write port and NumReadPorts independent read ports.
// Latency: write visible WriteLatency cycles after wr_valid (WriteLatency-1 with bypass); read data ReadLatency cycles after request.
// Backpressure: none; every write commits and every read request yields exactly one response.
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   wr_valid/wr_addr      write request and address
//   wr_data/wr_word_en    write data and per-word enable (word w = bits [w*WordWidth +: WordWidth])
//   rd_addr_valid/rd_addr per-port request; port p address at [p*AddrWidth +: AddrWidth]
//   rd_data_valid/rd_data per-port response; port p data at [p*BitWidth +: BitWidth]
//
// Build option: define BR_RAM_FLOPS_NR1W_ZERO_UNINIT_EN to keep a written-entry vector so that
// never-written entries (since the last reset) read as all-zero without resetting the array.
module br_ram_flops_nr1w #(
  parameter int Depth        = 2,
  parameter int BitWidth     = 1,
  parameter int NumReadPorts = 1,
  parameter int WordWidth    = BitWidth,
  parameter int WriteLatency = 1,
  parameter int ReadLatency  = 0,
  parameter int EnableBypass = 0,
  parameter int EnableReset  = 0,
  localparam int NumWords    = BitWidth / WordWidth,
  localparam int AddrWidth   = $clog2(Depth)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_valid,
  input  logic [AddrWidth-1:0]              wr_addr,
  input  logic [BitWidth-1:0]               wr_data,
  input  logic [NumWords-1:0]               wr_word_en,
  input  logic [NumReadPorts-1:0]           rd_addr_valid,
  input  logic [NumReadPorts*AddrWidth-1:0] rd_addr,
  output logic [NumReadPorts-1:0]           rd_data_valid,
  output logic [NumReadPorts*BitWidth-1:0]  rd_data
);

  // Commit point of the write pipeline: the one write that updates the array this cycle.
  logic                 cm_vld;
  logic [AddrWidth-1:0] cm_addr;
  logic [BitWidth-1:0]  cm_data;
  logic [NumWords-1:0]  cm_en;
  logic [BitWidth-1:0]  cm_mask;

  //--------------------------------------------------------------------------
  // Write pipeline
  //--------------------------------------------------------------------------
  if (WriteLatency == 1) begin : g_wr_direct
    assign cm_vld  = wr_valid;
    assign cm_addr = wr_addr;
    assign cm_data = wr_data;
    assign cm_en   = wr_word_en;
  end else begin : g_wr_pipe
    localparam int NumStages = WriteLatency - 1;

    logic [NumStages-1:0] vld_q;
    logic [AddrWidth-1:0] addr_q [NumStages];
    logic [BitWidth-1:0]  data_q [NumStages];
    logic [NumWords-1:0]  en_q   [NumStages];

    // Only the valids are reset: clearing them drops every in-flight write.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= wr_valid;
        for (int s = 1; s < NumStages; s++) begin
          vld_q[s] <= vld_q[s-1];
        end
      end
    end

    // Payload only moves alongside a valid write.
    always_ff @(posedge clk) begin
      if (wr_valid) begin
        addr_q[0] <= wr_addr;
        data_q[0] <= wr_data;
        en_q[0]   <= wr_word_en;
      end
      for (int s = 1; s < NumStages; s++) begin
        if (vld_q[s-1]) begin
          addr_q[s] <= addr_q[s-1];
          data_q[s] <= data_q[s-1];
          en_q[s]   <= en_q[s-1];
        end
      end
    end

    assign cm_vld  = vld_q[NumStages-1];
    assign cm_addr = addr_q[NumStages-1];
    assign cm_data = data_q[NumStages-1];
    assign cm_en   = en_q[NumStages-1];
  end

  // Expand word enables to a bit mask shared by the array update and the bypass merge.
  for (genvar w = 0; w < NumWords; w++) begin : g_mask
    assign cm_mask[w*WordWidth +: WordWidth] = {WordWidth{cm_en[w]}};
  end

  //--------------------------------------------------------------------------
  // Storage array
  //--------------------------------------------------------------------------
  logic [BitWidth-1:0] mem_q [Depth];

  if (EnableReset != 0) begin : g_mem_rst
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < Depth; i++) begin
          mem_q[i] <= '0;
        end
      end else if (cm_vld) begin
        mem_q[cm_addr] <= (mem_q[cm_addr] & ~cm_mask) | (cm_data & cm_mask);
      end
    end
  end else begin : g_mem_nrst
    always_ff @(posedge clk) begin
      if (cm_vld) begin
        mem_q[cm_addr] <= (mem_q[cm_addr] & ~cm_mask) | (cm_data & cm_mask);
      end
    end
  end

`ifdef BR_RAM_FLOPS_NR1W_ZERO_UNINIT_EN
  // Marks entries that received at least one enabled word since reset.
  logic [Depth-1:0] written_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written_q <= '0;
    end else if (cm_vld && (|cm_en)) begin
      written_q[cm_addr] <= 1'b1;
    end
  end
`endif

  //--------------------------------------------------------------------------
  // Read ports
  //--------------------------------------------------------------------------
  for (genvar p = 0; p < NumReadPorts; p++) begin : g_rd
    logic [AddrWidth-1:0] addr;
    logic [BitWidth-1:0]  stored;
    logic [BitWidth-1:0]  raw;

    assign addr = rd_addr[p*AddrWidth +: AddrWidth];

`ifdef BR_RAM_FLOPS_NR1W_ZERO_UNINIT_EN
    // Uses the pre-commit written bit, so a same-cycle first write does not count.
    assign stored = written_q[addr] ? mem_q[addr] : '0;
`else
    assign stored = mem_q[addr];
`endif

    if (EnableBypass != 0) begin : g_byp
      logic hit;
      assign hit = cm_vld && (cm_addr == addr);
      // Enabled words come from the committing write, the rest from storage.
      assign raw = hit ? ((stored & ~cm_mask) | (cm_data & cm_mask)) : stored;

`ifndef SYNTHESIS
      a_byp_data: assert property (@(posedge clk) disable iff (!rst_n)
        hit |-> (((raw ^ cm_data) & cm_mask) == '0));
`endif
    end else begin : g_nbyp
      assign raw = stored;
    end

    if (ReadLatency == 0) begin : g_rd_comb
      assign rd_data_valid[p]               = rd_addr_valid[p];
      assign rd_data[p*BitWidth +: BitWidth] = raw;
    end else begin : g_rd_pipe
      logic [ReadLatency-1:0] vld_q;
      logic [BitWidth-1:0]    dat_q [ReadLatency];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= rd_addr_valid[p];
          for (int s = 1; s < ReadLatency; s++) begin
            vld_q[s] <= vld_q[s-1];
          end
        end
      end

      // Data is captured in the request cycle; later commits cannot alter it.
      always_ff @(posedge clk) begin
        if (rd_addr_valid[p]) begin
          dat_q[0] <= raw;
        end
        for (int s = 1; s < ReadLatency; s++) begin
          if (vld_q[s-1]) begin
            dat_q[s] <= dat_q[s-1];
          end
        end
      end

      assign rd_data_valid[p]               = vld_q[ReadLatency-1];
      assign rd_data[p*BitWidth +: BitWidth] = dat_q[ReadLatency-1];
    end

`ifndef SYNTHESIS
    a_rd_addr_range: assert property (@(posedge clk) disable iff (!rst_n)
      rd_addr_valid[p] |-> (int'(addr) < Depth));
`endif
  end

  //--------------------------------------------------------------------------
  // Checks
  //--------------------------------------------------------------------------
`ifndef SYNTHESIS
  localparam bit ParamsOk = (Depth >= 2) && (BitWidth >= 1) && (NumReadPorts >= 1) &&
                            (WordWidth >= 1) && ((BitWidth % WordWidth) == 0) &&
                            (WriteLatency >= 1) && (ReadLatency >= 0);

  a_params: assert property (@(posedge clk) ParamsOk);

  a_wr_addr_range: assert property (@(posedge clk) disable iff (!rst_n)
    wr_valid |-> (int'(wr_addr) < Depth));

  if (ReadLatency == 0) begin : g_lat_chk_comb
    a_rd_lat: assert property (@(posedge clk) disable iff (!rst_n)
      rd_data_valid == rd_addr_valid);
  end else begin : g_lat_chk_pipe
    localparam int AgeW = $clog2(ReadLatency + 1);
    // Counts edges since reset release so the check ignores requests lost to reset.
    logic [AgeW-1:0] age_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        age_q <= '0;
      end else if (age_q != AgeW'(ReadLatency)) begin
        age_q <= age_q + AgeW'(1);
      end
    end

    a_rd_lat: assert property (@(posedge clk) disable iff (!rst_n)
      (age_q == AgeW'(ReadLatency)) |-> (rd_data_valid == $past(rd_addr_valid, ReadLatency)));
  end
`endif

endmodule

// File: tb/tb_br_ram_flops_nr1w.sv
// tb_br_ram_flops_nr1w: directed bench for br_ram_flops_nr1w across four configurations.
// Inputs change 2 time units after each rising edge; outputs are checked 1 unit later.
// u0/u1: 4x8, 4-bit words, WL1 RL0, without/with bypass; u2: 3 ports RL2; u3: WL3 RL1.
module tb_br_ram_flops_nr1w;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  // Shared stimulus for u0 (no bypass) and u1 (bypass).
  logic       a_wr_valid;
  logic [1:0] a_wr_addr;
  logic [7:0] a_wr_data;
  logic [1:0] a_wr_en;
  logic [0:0] a_rd_v;
  logic [1:0] a_rd_addr;
  logic [0:0] u0_rv;
  logic [7:0] u0_rd;
  logic [0:0] u1_rv;
  logic [7:0] u1_rd;

  // u2: three read ports, ReadLatency 2.
  logic        b_wr_valid;
  logic [1:0]  b_wr_addr;
  logic [7:0]  b_wr_data;
  logic [0:0]  b_wr_en;
  logic [2:0]  b_rd_v;
  logic [5:0]  b_rd_addr;
  logic [2:0]  b_rv;
  logic [23:0] b_rd;

  // u3: WriteLatency 3, ReadLatency 1, array not reset.
  logic       c_wr_valid;
  logic [1:0] c_wr_addr;
  logic [7:0] c_wr_data;
  logic [0:0] c_wr_en;
  logic [0:0] c_rd_v;
  logic [1:0] c_rd_addr;
  logic [0:0] c_rv;
  logic [7:0] c_rd;

  br_ram_flops_nr1w #(
    .Depth(4), .BitWidth(8), .NumReadPorts(1), .WordWidth(4),
    .WriteLatency(1), .ReadLatency(0), .EnableBypass(0), .EnableReset(1)
  ) u0 (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(a_wr_valid), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_word_en(a_wr_en),
    .rd_addr_valid(a_rd_v), .rd_addr(a_rd_addr),
    .rd_data_valid(u0_rv), .rd_data(u0_rd)
  );

  br_ram_flops_nr1w #(
    .Depth(4), .BitWidth(8), .NumReadPorts(1), .WordWidth(4),
    .WriteLatency(1), .ReadLatency(0), .EnableBypass(1), .EnableReset(1)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(a_wr_valid), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_word_en(a_wr_en),
    .rd_addr_valid(a_rd_v), .rd_addr(a_rd_addr),
    .rd_data_valid(u1_rv), .rd_data(u1_rd)
  );

  br_ram_flops_nr1w #(
    .Depth(4), .BitWidth(8), .NumReadPorts(3), .WordWidth(8),
    .WriteLatency(1), .ReadLatency(2), .EnableBypass(0), .EnableReset(0)
  ) u2 (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(b_wr_valid), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_word_en(b_wr_en),
    .rd_addr_valid(b_rd_v), .rd_addr(b_rd_addr),
    .rd_data_valid(b_rv), .rd_data(b_rd)
  );

  br_ram_flops_nr1w #(
    .Depth(4), .BitWidth(8), .NumReadPorts(1), .WordWidth(8),
    .WriteLatency(3), .ReadLatency(1), .EnableBypass(0), .EnableReset(0)
  ) u3 (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(c_wr_valid), .wr_addr(c_wr_addr), .wr_data(c_wr_data), .wr_word_en(c_wr_en),
    .rd_addr_valid(c_rd_v), .rd_addr(c_rd_addr),
    .rd_data_valid(c_rv), .rd_data(c_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    a_wr_valid = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_wr_en = 2'b11; a_rd_v = 1'b0; a_rd_addr = '0;
    b_wr_valid = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_wr_en = 1'b1;  b_rd_v = 3'b111; b_rd_addr = '0;
    c_wr_valid = 1'b0; c_wr_addr = '0; c_wr_data = '0; c_wr_en = 1'b1;  c_rd_v = 1'b1; c_rd_addr = '0;

    // Requests held during reset must never produce a response.
    tick();
    tick();
    #1;
    check("rst_u2_vld", 32'(b_rv), 32'h0);
    check("rst_u3_vld", 32'(c_rv), 32'h0);
    b_rd_v = 3'b000;
    c_rd_v = 1'b0;
    tick();
    rst_n = 1'b1;

    // C1
    tick();
    a_wr_valid = 1'b1; a_wr_addr = 2'd2; a_wr_data = 8'hA5; a_wr_en = 2'b11; a_rd_v = 1'b1; a_rd_addr = 2'd2;
    b_wr_valid = 1'b1; b_wr_addr = 2'd0; b_wr_data = 8'h10;
    c_wr_valid = 1'b1; c_wr_addr = 2'd1; c_wr_data = 8'h5A;
    #1;
    check("nobyp_same_cycle_old", 32'(u0_rd), 32'h00);
    check("rl0_vld", 32'(u0_rv), 32'h1);
    check("byp_same_cycle_a5", 32'(u1_rd), 32'hA5);

    // C2
    tick();
    a_wr_valid = 1'b0;
    b_wr_addr = 2'd1; b_wr_data = 8'h20;
    c_wr_valid = 1'b0;
    #1;
    check("nobyp_next_cycle_a5", 32'(u0_rd), 32'hA5);

    // C3
    tick();
    a_wr_valid = 1'b1; a_wr_addr = 2'd1; a_wr_data = 8'h3C; a_rd_addr = 2'd1;
    b_wr_addr = 2'd2; b_wr_data = 8'h30;
    #1;
    check("byp_same_cycle_3c", 32'(u1_rd), 32'h3C);
    check("nobyp_3c_old", 32'(u0_rd), 32'h00);

    // C4: u2 ports 0..2 read addrs 2,0,2; u3 reads addr 1 and starts a second write.
    tick();
    a_wr_addr = 2'd0; a_wr_data = 8'hFF; a_rd_addr = 2'd0;
    b_wr_valid = 1'b0; b_rd_v = 3'b111; b_rd_addr = {2'd2, 2'd0, 2'd2};
    c_rd_v = 1'b1; c_rd_addr = 2'd1; c_wr_valid = 1'b1; c_wr_addr = 2'd1; c_wr_data = 8'h6B;
    #1;
    check("pre_ff_old", 32'(u0_rd), 32'h00);
    check("byp_ff", 32'(u1_rd), 32'hFF);

    // C5: upper-word-only write of 0x12 over 0xFF.
    tick();
    a_wr_data = 8'h12; a_wr_en = 2'b10;
    b_rd_v = 3'b010; b_rd_addr = {2'd0, 2'd1, 2'd0};
    c_wr_valid = 1'b0; c_rd_v = 1'b0;
    #1;
    check("word_en_old", 32'(u0_rd), 32'hFF);
    check("byp_word_en_1f", 32'(u1_rd), 32'h1F);
    check("rl2_t1_vld", 32'(b_rv), 32'h0);
    check("rl1_vld", 32'(c_rv), 32'h1);
    check("wl3_commit_5a", 32'(c_rd), 32'h5A);

    // C6: valid write with no enabled words; u2 writes 0x44 to addr 0 while port 0 reads it.
    tick();
    a_wr_data = 8'h55; a_wr_en = 2'b00;
    b_wr_valid = 1'b1; b_wr_addr = 2'd0; b_wr_data = 8'h44; b_rd_v = 3'b001; b_rd_addr = 6'd0;
    c_rd_v = 1'b1; c_rd_addr = 2'd1;
    #1;
    check("word_en_merge_1f", 32'(u0_rd), 32'h1F);
    check("byp_no_words_1f", 32'(u1_rd), 32'h1F);
    check("rl2_t2_vld", 32'(b_rv), 32'h7);
    check("rl2_t2_dat", 32'(b_rd), 32'h301030);
    check("rl1_idle_vld", 32'(c_rv), 32'h0);

    // C7
    tick();
    a_wr_valid = 1'b0;
    b_wr_valid = 1'b0; b_rd_v = 3'b100; b_rd_addr = 6'd0;
    #1;
    check("noop_write_1f", 32'(u0_rd), 32'h1F);
    check("rl2_port1_vld", 32'(b_rv), 32'h2);
    check("rl2_port1_dat", 32'(b_rd[15:8]), 32'h20);
    check("wl3_before_commit", 32'(c_rd), 32'h5A);

    // C8: u3 write 0x7C that reset will catch in flight.
    tick();
    a_rd_v = 1'b0;
    b_rd_v = 3'b000;
    c_rd_v = 1'b0; c_wr_valid = 1'b1; c_wr_addr = 2'd1; c_wr_data = 8'h7C;
    #1;
    check("rl2_sampled_at_req", 32'(b_rv), 32'h1);
    check("rl2_sampled_dat", 32'(b_rd[7:0]), 32'h10);
    check("wl3_after_commit", 32'(c_rd), 32'h6B);

    // C9: reset asserted one cycle after the write.
    tick();
    #1;
    check("rl2_port2_vld", 32'(b_rv), 32'h4);
    check("rl2_port2_dat", 32'(b_rd[23:16]), 32'h44);
    rst_n = 1'b0;
    c_wr_valid = 1'b0;
    b_rd_v = 3'b111;
    c_rd_v = 1'b1;
    #1;
    check("async_rst_u2_vld", 32'(b_rv), 32'h0);
    check("async_rst_u3_vld", 32'(c_rv), 32'h0);

    tick();
    #1;
    check("rst_held_u2_vld", 32'(b_rv), 32'h0);
    check("rst_held_u3_vld", 32'(c_rv), 32'h0);
    b_rd_v = 3'b000;
    c_rd_v = 1'b0;
    tick();
    rst_n = 1'b1;

    tick();
    a_rd_v = 1'b1; a_rd_addr = 2'd0;
    c_rd_v = 1'b1; c_rd_addr = 2'd1;
    #1;
    check("array_reset_u0", 32'(u0_rd), 32'h00);

    tick();
    a_rd_v = 1'b0;
    c_rd_v = 1'b0;
    #1;
    check("post_rst_vld", 32'(c_rv), 32'h1);
`ifdef BR_RAM_FLOPS_NR1W_ZERO_UNINIT_EN
    check("rst_drop_inflight", 32'(c_rd), 32'h00);
`else
    check("rst_drop_inflight", 32'(c_rd), 32'h6B);
`endif

`ifdef BR_RAM_FLOPS_NR1W_ZERO_UNINIT_EN
    tick();
    c_rd_v = 1'b1; c_rd_addr = 2'd3;
    tick();
    #1;
    check("zu_unwritten", 32'(c_rd), 32'h00);
    c_rd_v = 1'b0; c_wr_valid = 1'b1; c_wr_addr = 2'd3; c_wr_data = 8'h77;
    tick();
    c_wr_valid = 1'b0;
    tick();
    tick();
    c_rd_v = 1'b1; c_rd_addr = 2'd3;
    tick();
    #1;
    check("zu_written", 32'(c_rd), 32'h77);
    c_rd_v = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    c_rd_v = 1'b1; c_rd_addr = 2'd3;
    tick();
    #1;
    check("zu_after_reset", 32'(c_rd), 32'h00);
    c_rd_v = 1'b0;
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
